fpu_apu_resp_adapter: RTL and testbench
=======================================

Name: fpu_apu_resp_adapter

Overview:
- Sits between the APU-side master port of the FPU interconnect and one FPU core; the core is attached through a generic valid/ready port.
- Unlike the previous wrapper, it honours apu_rready_i. Core results land in a parametrised response FIFO.
- A credit counter grants a request only when a FIFO slot is guaranteed, so the core output never stalls (fpu_out_ready_o is constantly 1).
- Packs {opcode, flags, ID} towards the core and unpacks the result, status and ID on return. Reports outstanding count and idle status.

Parameters:
- ID_WIDTH, 9, APU transaction ID width.
- NB_ARGS, 3, number of operands.
- DATA_WIDTH, 32, operand/result width.
- OPCODE_WIDTH, 6, apu_op width.
- FLAGS_IN_WIDTH, 15, request flag width.
- FLAGS_OUT_WIDTH, 5, response status width.
- RESP_DEPTH, 4, response FIFO entries; must be >=2. This is also the maximum number of outstanding operations.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- apu_req_i  in  1  request valid
- apu_gnt_o  out  1  request accepted this cycle
- apu_ID_i  in  ID_WIDTH  request ID
- apu_operands_i  in  NB_ARGS*DATA_WIDTH  operands
- apu_op_i  in  OPCODE_WIDTH  opcode
- apu_flags_i  in  FLAGS_IN_WIDTH  request flags
- apu_rready_i  in  1  response consumer ready
- apu_rvalid_o  out  1  response valid
- apu_rdata_o  out  DATA_WIDTH  result
- apu_rflags_o  out  FLAGS_OUT_WIDTH  status
- apu_rID_o  out  ID_WIDTH  response ID
- fpu_in_valid_o  out  1  core request valid
- fpu_in_ready_i  in  1  core request ready
- fpu_operands_o  out  NB_ARGS*DATA_WIDTH  to core
- fpu_op_o  out  OPCODE_WIDTH  to core
- fpu_flags_o  out  FLAGS_IN_WIDTH  to core
- fpu_tag_o  out  ID_WIDTH  to core
- fpu_out_valid_i  in  1  core result valid
- fpu_out_ready_o  out  1  constant 1
- fpu_result_i  in  DATA_WIDTH  core result
- fpu_status_i  in  FLAGS_OUT_WIDTH  core status
- fpu_tag_i  in  ID_WIDTH  core tag
- outstanding_o  out  $clog2(RESP_DEPTH+1)  in-flight count plus FIFO count
- idle_o  out  1  outstanding_o==0

Behaviour:
- Reset: FIFO empty, counter 0. apu_rvalid_o=0, apu_rdata_o/apu_rflags_o/apu_rID_o=0, idle_o=1, fpu_out_ready_o=1. Reset mid-operation drops all FIFO contents and in-flight credits; core results arriving after reset are the integrator's responsibility (core is reset on the same rst_n).
- Request path is combinational pass-through:
  - fpu_in_valid_o = apu_req_i & credit_ok.
  - apu_gnt_o = apu_req_i & credit_ok & fpu_in_ready_i.
  - credit_ok = (outstanding < RESP_DEPTH).
  - Operands, op, flags and ID are forwarded unchanged as fpu_operands_o, fpu_op_o, fpu_flags_o and fpu_tag_o.
- Counter: +1 on apu_gnt_o; -1 on response pop (apu_rvalid_o & apu_rready_i). Both in the same cycle: unchanged. It never exceeds RESP_DEPTH and never underflows. An underflow attempt (pop when 0) triggers a simulation assertion.
- FIFO push: on fpu_out_valid_i, write {fpu_result_i, fpu_status_i, fpu_tag_i}. Push is unconditional. Overflow is impossible by the credit rule; a simulation assertion fires if push occurs while full and no pop occurs.
- FIFO output is registered (no bypass): a result pushed in cycle N is visible on apu_rvalid_o/apu_r*_o in cycle N+1 at the earliest. Added latency over the core is exactly 1 cycle when the FIFO is empty.
- Pop when apu_rvalid_o & apu_rready_i. Simultaneous push and pop is legal, including when the FIFO is full.
- Responses are kept in core completion order; no reordering by ID.
- With apu_rvalid_o=1 and apu_rready_i=0, all apu_r*_o hold stable.
- Pointers wrap modulo RESP_DEPTH (non-power-of-2 depths supported); full/empty are derived from the occupancy count.

Decomposition:
- Package fpu_interco_pkg holds:
  - apu_resp_t struct {data, flags, id}, parametrised via localparams matching the defaults;
  - function clog2_cnt(depth) for counter width.
- One sub-module: fpu_resp_fifo. It is a generic synchronous FIFO with parameters WIDTH and DEPTH and push/pop/full/empty/count ports, instantiated with WIDTH = DATA_WIDTH+FLAGS_OUT_WIDTH+ID_WIDTH.
- The credit logic stays in the top module.

Test Plan:
- Single op: req ID=0x05, core returns result 0x3F800000, status 0 after 3 cycles -> apu_rvalid_o exactly one cycle after fpu_out_valid_i, rdata=0x3F800000, rID=0x05; idle_o back to 1 after the pop.
- Credit limit: RESP_DEPTH=4, apu_rready_i=0, five back-to-back reqs -> four grants, 5th held with apu_gnt_o=0 and fpu_in_valid_o=0, outstanding_o=4. Raise rready -> one pop, then the 5th is granted the next cycle.
- Backpressure hold: rvalid=1 with rready toggling 0/1 every cycle for 3 queued responses (IDs 1,2,3) -> outputs stable while stalled, delivered in order 1,2,3, no duplicates or drops.
- Simultaneous events: FIFO full, pop and core push in the same cycle, plus a grant and a pop in the same cycle -> count is correct and no assertion fires.
- Core stall: fpu_in_ready_i=0 with apu_req_i=1 -> fpu_in_valid_o=1, apu_gnt_o=0, counter unchanged.
- Reset mid-operation: deassert rst_n with 2 entries queued -> apu_rvalid_o=0 immediately (asynchronously), outstanding_o=0, idle_o=1.

Source files
------------

// File: rtl/fpu_interco_pkg.sv
// Shared types and helpers for the FPU interconnect APU response adapter.
package fpu_interco_pkg;

   localparam int RESP_DATA_WIDTH  = 32;
   localparam int RESP_FLAGS_WIDTH = 5;
   localparam int RESP_ID_WIDTH    = 9;
   localparam int RESP_WIDTH       = RESP_DATA_WIDTH + RESP_FLAGS_WIDTH + RESP_ID_WIDTH;

   // One response as it travels back to the APU: result, status, transaction ID.
   typedef struct packed {
      logic [RESP_DATA_WIDTH-1:0]  data;
      logic [RESP_FLAGS_WIDTH-1:0] flags;
      logic [RESP_ID_WIDTH-1:0]    id;
   } apu_resp_t;

   // Width of a counter that must hold every value from 0 up to depth inclusive.
   function automatic int clog2_cnt(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fpu_apu_resp_adapter_if.sv
// Bundle of the APU request/response port and the generic FPU core port.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both 1.
// apu_req_i/apu_gnt_o and fpu_in_valid_o/fpu_in_ready_i form the request
// path; apu_rvalid_o/apu_rready_i form the response path, and the response
// payload stays stable while valid is high and ready is low.
// fpu_out_valid_i is never back-pressured (fpu_out_ready_o is tied to 1).
interface fpu_apu_resp_adapter_if #(
   parameter int ID_WIDTH        = 9,
   parameter int NB_ARGS         = 3,
   parameter int DATA_WIDTH      = 32,
   parameter int OPCODE_WIDTH    = 6,
   parameter int FLAGS_IN_WIDTH  = 15,
   parameter int FLAGS_OUT_WIDTH = 5
);
   logic                          apu_req_i;
   logic                          apu_gnt_o;
   logic [ID_WIDTH-1:0]           apu_ID_i;
   logic [NB_ARGS*DATA_WIDTH-1:0] apu_operands_i;
   logic [OPCODE_WIDTH-1:0]       apu_op_i;
   logic [FLAGS_IN_WIDTH-1:0]     apu_flags_i;
   logic                          apu_rready_i;
   logic                          apu_rvalid_o;
   logic [DATA_WIDTH-1:0]         apu_rdata_o;
   logic [FLAGS_OUT_WIDTH-1:0]    apu_rflags_o;
   logic [ID_WIDTH-1:0]           apu_rID_o;
   logic                          fpu_in_valid_o;
   logic                          fpu_in_ready_i;
   logic [NB_ARGS*DATA_WIDTH-1:0] fpu_operands_o;
   logic [OPCODE_WIDTH-1:0]       fpu_op_o;
   logic [FLAGS_IN_WIDTH-1:0]     fpu_flags_o;
   logic [ID_WIDTH-1:0]           fpu_tag_o;
   logic                          fpu_out_valid_i;
   logic                          fpu_out_ready_o;
   logic [DATA_WIDTH-1:0]         fpu_result_i;
   logic [FLAGS_OUT_WIDTH-1:0]    fpu_status_i;
   logic [ID_WIDTH-1:0]           fpu_tag_i;

   // Adapter view.
   modport slave (
      input  apu_req_i, apu_ID_i, apu_operands_i, apu_op_i, apu_flags_i, apu_rready_i,
             fpu_in_ready_i, fpu_out_valid_i, fpu_result_i, fpu_status_i, fpu_tag_i,
      output apu_gnt_o, apu_rvalid_o, apu_rdata_o, apu_rflags_o, apu_rID_o,
             fpu_in_valid_o, fpu_operands_o, fpu_op_o, fpu_flags_o, fpu_tag_o, fpu_out_ready_o
   );

   // Environment view (APU master plus FPU core).
   modport master (
      output apu_req_i, apu_ID_i, apu_operands_i, apu_op_i, apu_flags_i, apu_rready_i,
             fpu_in_ready_i, fpu_out_valid_i, fpu_result_i, fpu_status_i, fpu_tag_i,
      input  apu_gnt_o, apu_rvalid_o, apu_rdata_o, apu_rflags_o, apu_rID_o,
             fpu_in_valid_o, fpu_operands_o, fpu_op_o, fpu_flags_o, fpu_tag_o, fpu_out_ready_o
   );
endinterface

// File: rtl/fpu_resp_fifo.sv
// Generic synchronous FIFO; output comes straight from storage (no
// write-to-read bypass), pointers wrap modulo DEPTH so any DEPTH >= 2 works.
module fpu_resp_fifo
   import fpu_interco_pkg::*;
#(
   parameter int WIDTH = RESP_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic [WIDTH-1:0]              wdata,
   input  logic                          pop,
   output logic [WIDTH-1:0]              rdata,
   output logic                          full,
   output logic                          empty,
   output logic [clog2_cnt(DEPTH)-1:0]   count
);
   localparam int PTR_WIDTH = $clog2(DEPTH);
   localparam int CNT_WIDTH = clog2_cnt(DEPTH);

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [PTR_WIDTH-1:0] wr_ptr;
   logic [PTR_WIDTH-1:0] rd_ptr;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 do_push;
   logic                 do_pop;

   function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
      return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
   endfunction

   assign empty   = (cnt == '0);
   assign full    = (cnt == CNT_WIDTH'(DEPTH));
   assign count   = cnt;
   assign do_pop  = pop & ~empty;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   // Empty reads return zero so the response bus is quiet when nothing is held.
   assign rdata   = empty ? '0 : mem[rd_ptr];

   // Storage write; contents need no reset because occupancy gates the output.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         if (do_push && !do_pop)      cnt <= cnt + CNT_WIDTH'(1);
         else if (do_pop && !do_push) cnt <= cnt - CNT_WIDTH'(1);
      end
   end

   overflow_chk: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/fpu_apu_resp_adapter.sv
// Adapter between the APU master port and one FPU core. Requests pass straight
// through; a credit counter only lets a request go when a response slot is
// reserved, so core results are always absorbed by the response FIFO.
module fpu_apu_resp_adapter
   import fpu_interco_pkg::*;
#(
   parameter int ID_WIDTH        = 9,
   parameter int NB_ARGS         = 3,
   parameter int DATA_WIDTH      = 32,
   parameter int OPCODE_WIDTH    = 6,
   parameter int FLAGS_IN_WIDTH  = 15,
   parameter int FLAGS_OUT_WIDTH = 5,
   parameter int RESP_DEPTH      = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   fpu_apu_resp_adapter_if.slave               bus,
   output logic [clog2_cnt(RESP_DEPTH)-1:0]    outstanding_o,
   output logic                                idle_o
);
   localparam int FIFO_WIDTH = DATA_WIDTH + FLAGS_OUT_WIDTH + ID_WIDTH;
   localparam int CNT_WIDTH  = clog2_cnt(RESP_DEPTH);

   logic                  credit_ok;
   logic                  gnt;
   logic                  pop;
   logic [CNT_WIDTH-1:0]  cnt;
   logic [FIFO_WIDTH-1:0] fifo_wdata;
   logic [FIFO_WIDTH-1:0] fifo_rdata;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [CNT_WIDTH-1:0]  fifo_count;

   // Request path: pure combinational forwarding, gated by credit.
   assign credit_ok          = (cnt < CNT_WIDTH'(RESP_DEPTH));
   assign bus.fpu_in_valid_o = bus.apu_req_i & credit_ok;
   assign gnt                = bus.apu_req_i & credit_ok & bus.fpu_in_ready_i;
   assign bus.apu_gnt_o      = gnt;
   assign bus.fpu_operands_o = bus.apu_operands_i;
   assign bus.fpu_op_o       = bus.apu_op_i;
   assign bus.fpu_flags_o    = bus.apu_flags_i;
   assign bus.fpu_tag_o      = bus.apu_ID_i;
   assign bus.fpu_out_ready_o = 1'b1;

   // Response path: FIFO head drives the APU response port.
   assign fifo_wdata       = {bus.fpu_result_i, bus.fpu_status_i, bus.fpu_tag_i};
   assign bus.apu_rvalid_o = ~fifo_empty;
   assign pop              = ~fifo_empty & bus.apu_rready_i;
   assign {bus.apu_rdata_o, bus.apu_rflags_o, bus.apu_rID_o} = fifo_rdata;

   fpu_resp_fifo #(
      .WIDTH (FIFO_WIDTH),
      .DEPTH (RESP_DEPTH)
   ) u_resp_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (bus.fpu_out_valid_i),
      .wdata (fifo_wdata),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Credit counter: in-flight operations plus responses waiting in the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (gnt && !pop) begin
         cnt <= cnt + CNT_WIDTH'(1);
      end else if (pop && !gnt && cnt != '0) begin
         cnt <= cnt - CNT_WIDTH'(1);
      end
   end

   assign outstanding_o = cnt;
   assign idle_o        = (cnt == '0);

   underflow_chk: assert property (@(posedge clk) disable iff (!rst_n) !(pop && !gnt && cnt == '0));
   // Every queued response was counted when its request was granted.
   fifo_in_credit_chk: assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= cnt);
   full_means_no_credit_chk: assert property (@(posedge clk) disable iff (!rst_n) !(fifo_full && credit_ok));

endmodule

// File: tb/tb_fpu_apu_resp_adapter.sv
// Directed plus randomized bench for fpu_apu_resp_adapter. The bench plays both
// the APU master and an in-order FPU core with variable latency; a transaction
// model (outstanding count, queue of expected responses) predicts every output.
module tb_fpu_apu_resp_adapter;
   import fpu_interco_pkg::*;

   localparam int DEPTH = 4;

   typedef struct {
      int        due;
      apu_resp_t resp;
   } core_op_t;

   logic       clk;
   logic       rst_n;
   logic [2:0] outstanding;
   logic       idle;

   fpu_apu_resp_adapter_if bus ();

   fpu_apu_resp_adapter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus),
      .outstanding_o (outstanding),
      .idle_o        (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   apu_resp_t exp_q[$];   // responses the APU should see, oldest first
   core_op_t  core_q[$];  // operations accepted by the core, in completion order
   int        m_out;      // requests granted but not yet popped
   int        cyc;
   int        last_due;
   int        lat;
   logic [31:0] next_result;
   logic [4:0]  next_status;
   int        n_cmp;
   int        n_bad;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic req, input logic [8:0] id);
      bus.apu_req_i      = req;
      bus.apu_ID_i       = id;
      bus.apu_operands_i = {$urandom, $urandom, $urandom};
      bus.apu_op_i       = 6'($urandom);
      bus.apu_flags_i    = 15'($urandom);
   endtask

   // One clock cycle: drive the core output, check all outputs against the
   // model, then advance the model across the coming rising edge.
   task automatic cycle();
      logic      fire;
      logic      exp_valid;
      logic      exp_gnt;
      logic      exp_pop;
      int        due;
      core_op_t  op;
      apu_resp_t tmp;
      fire = (core_q.size() > 0) && (core_q[0].due <= cyc);
      bus.fpu_out_valid_i = fire;
      if (fire) {bus.fpu_result_i, bus.fpu_status_i, bus.fpu_tag_i} = core_q[0].resp;
      else      {bus.fpu_result_i, bus.fpu_status_i, bus.fpu_tag_i} = 46'({$urandom, $urandom});
      #1;
      exp_valid = bus.apu_req_i && (m_out < DEPTH);
      exp_gnt   = exp_valid && bus.fpu_in_ready_i;
      check("in_valid", 128'(bus.fpu_in_valid_o), 128'(exp_valid));
      check("gnt", 128'(bus.apu_gnt_o), 128'(exp_gnt));
      check("out_ready", 128'(bus.fpu_out_ready_o), 128'(1'b1));
      check("outstanding", 128'(outstanding), 128'(m_out));
      check("idle", 128'(idle), 128'(m_out == 0));
      check("rvalid", 128'(bus.apu_rvalid_o), 128'(exp_q.size() > 0));
      if (exp_q.size() > 0)
         check("resp", 128'({bus.apu_rdata_o, bus.apu_rflags_o, bus.apu_rID_o}), 128'(exp_q[0]));
      check("fwd_tag", 128'(bus.fpu_tag_o), 128'(bus.apu_ID_i));
      check("fwd_op", 128'(bus.fpu_op_o), 128'(bus.apu_op_i));
      check("fwd_flags", 128'(bus.fpu_flags_o), 128'(bus.apu_flags_i));
      check("fwd_operands", 128'(bus.fpu_operands_o), 128'(bus.apu_operands_i));
      exp_pop = (exp_q.size() > 0) && bus.apu_rready_i;
      if (exp_pop) tmp = exp_q.pop_front();
      if (fire) begin
         op = core_q.pop_front();
         exp_q.push_back(op.resp);
      end
      m_out = m_out + int'(exp_gnt) - int'(exp_pop);
      if (exp_gnt) begin
         due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
         op.due  = due;
         op.resp = {next_result, next_status, bus.apu_ID_i};
         core_q.push_back(op);
         last_due = due;
      end
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; cyc = 0; m_out = 0; last_due = 0; lat = 3;
      next_result = 32'h3F800000; next_status = 5'h0;
      rst_n = 1'b0;
      set_req(1'b0, 9'h0);
      bus.apu_rready_i = 1'b0; bus.fpu_in_ready_i = 1'b1;
      bus.fpu_out_valid_i = 1'b0; bus.fpu_result_i = '0; bus.fpu_status_i = '0; bus.fpu_tag_i = '0;
      repeat (2) @(negedge clk);

      // Reset state.
      check("rst_rvalid", 128'(bus.apu_rvalid_o), 128'(1'b0));
      check("rst_rdata", 128'(bus.apu_rdata_o), 128'(0));
      check("rst_rflags", 128'(bus.apu_rflags_o), 128'(0));
      check("rst_rid", 128'(bus.apu_rID_o), 128'(0));
      check("rst_idle", 128'(idle), 128'(1'b1));
      check("rst_outstanding", 128'(outstanding), 128'(0));
      check("rst_out_ready", 128'(bus.fpu_out_ready_o), 128'(1'b1));
      rst_n = 1'b1;

      // Single op, core latency 3.
      bus.apu_rready_i = 1'b1;
      set_req(1'b1, 9'h05);
      cycle();
      set_req(1'b0, 9'h0);
      repeat (6) cycle();
      check("single_idle", 128'(idle), 128'(1'b1));

      // Credit limit: four grants, the fifth waits for a pop.
      bus.apu_rready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         next_result = $urandom;
         set_req(1'b1, 9'(16 + i));
         cycle();
      end
      set_req(1'b1, 9'd20);
      repeat (6) cycle();
      check("credit_full", 128'(outstanding), 128'(DEPTH));
      check("credit_held", 128'(bus.apu_gnt_o), 128'(1'b0));
      bus.apu_rready_i = 1'b1;
      cycle();   // pop, no grant yet
      cycle();   // grant of ID 20 together with a pop
      set_req(1'b0, 9'h0);
      repeat (10) cycle();

      // Backpressure: three responses, ready toggling every cycle.
      bus.apu_rready_i = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         next_result = $urandom;
         set_req(1'b1, 9'(i));
         cycle();
      end
      set_req(1'b0, 9'h0);
      repeat (4) cycle();
      for (int i = 0; i < 8; i++) begin
         bus.apu_rready_i = i[0];
         cycle();
      end
      bus.apu_rready_i = 1'b1;
      repeat (4) cycle();

      // Push into a nearly full FIFO while popping, then grant while popping.
      bus.apu_rready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         next_result = $urandom;
         set_req(1'b1, 9'(32 + i));
         cycle();
      end
      set_req(1'b0, 9'h0);
      repeat (2) cycle();
      bus.apu_rready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         next_result = $urandom;
         set_req(1'b1, 9'(40 + i));
         cycle();
      end
      set_req(1'b0, 9'h0);
      repeat (10) cycle();

      // Core stall: valid offered, nothing granted.
      bus.fpu_in_ready_i = 1'b0;
      set_req(1'b1, 9'h1AA);
      repeat (3) cycle();
      bus.fpu_in_ready_i = 1'b1;
      cycle();
      set_req(1'b0, 9'h0);
      repeat (6) cycle();

      // Randomized traffic with variable core latency.
      for (int i = 0; i < 400; i++) begin
         set_req($urandom_range(0, 3) != 0, 9'($urandom));
         bus.fpu_in_ready_i = $urandom_range(0, 3) != 0;
         bus.apu_rready_i   = $urandom_range(0, 1) != 0;
         lat         = $urandom_range(1, 5);
         next_result = $urandom;
         next_status = 5'($urandom_range(0, 31));
         cycle();
      end
      set_req(1'b0, 9'h0);
      bus.fpu_in_ready_i = 1'b1;
      bus.apu_rready_i   = 1'b1;
      repeat (12) cycle();

      // Reset while two responses are queued.
      bus.apu_rready_i = 1'b0;
      lat = 2;
      set_req(1'b1, 9'h0A1);
      cycle();
      set_req(1'b1, 9'h0A2);
      cycle();
      set_req(1'b0, 9'h0);
      repeat (4) cycle();
      check("pre_rst_outstanding", 128'(outstanding), 128'(2));
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_rvalid", 128'(bus.apu_rvalid_o), 128'(1'b0));
      check("mid_rst_outstanding", 128'(outstanding), 128'(0));
      check("mid_rst_idle", 128'(idle), 128'(1'b1));
      exp_q.delete();
      core_q.delete();
      m_out = 0;
      last_due = cyc;
      @(negedge clk);
      rst_n = 1'b1;
      bus.apu_rready_i = 1'b1;
      set_req(1'b1, 9'h0B0);
      cycle();
      set_req(1'b0, 9'h0);
      repeat (5) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
